// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the 4x4 keypad scanner.
// The scanner uses the master modport; the consumer/keypad model uses slave.
interface keypad_scanner_if;
  logic       sw_clk;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  sw_clk, key_row,
    output key_col, key_code, key_valid, key_held
  );

  modport slave (
    output sw_clk, key_row,
    input  key_col, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner and debouncer: one full column scan per rising
// edge of sw_clk, key accepted after DEBOUNCE_N identical scan results.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no column driven, waiting for scan_tick
// S_SETTLE | column col driven low, waiting SETTLE_CYC cycles
// S_SAMPLE | column col still driven, rows latched into row_map
// S_EVAL   | columns released, map reduced and debounced
module keypad_scanner #(
  parameter int SETTLE_CYC = 64,
  parameter int DEBOUNCE_N = 2
) (
  input  logic               clock_50m,
  input  logic               rst,
  keypad_scanner_if.master   kp
);
  localparam int CNT_W = $clog2(SETTLE_CYC);
  localparam int SC_W  = $clog2(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SC_W-1:0]  DB_MAX      = SC_W'(DEBOUNCE_N);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_EVAL   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       col;
  logic [CNT_W-1:0] settle_cnt;
  logic [15:0]      row_map;

  logic             sw_s1, sw_s2, sw_d;
  logic [3:0]       row_s1, row_s2;
  logic             scan_tick;

  logic             cand_key;
  logic [3:0]       cand_code;
  logic [SC_W-1:0]  stable_cnt;

  logic [3:0]       code_q;
  logic             valid_q;
  logic             held_q;

  logic [4:0]       hits;
  logic             res_key;
  logic [3:0]       res_code;
  logic             same;
  logic [SC_W-1:0]  cnt_next;
  logic             differs;
  logic             accept;

  assign scan_tick    = sw_s2 & ~sw_d;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

  // Column drive decodes straight from state so an async reset releases it at once.
  always_comb begin
    kp.key_col = 4'b1111;
    if (state == S_SETTLE || state == S_SAMPLE) kp.key_col[col] = 1'b0;
  end

  // Map bit index is row*4 + col, which is also the key code.
  always_comb begin
    hits     = 5'd0;
    res_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (row_map[i]) begin
        hits     = hits + 5'd1;
        res_code = 4'(i);
      end
    end
    res_key = (hits == 5'd1);
    if (!res_key) res_code = 4'd0;
  end

  // NONE always carries code 0, so a plain compare covers both result kinds.
  always_comb begin
    same     = (res_key == cand_key) && (res_code == cand_code);
    cnt_next = SC_W'(1);
    if (same) cnt_next = (stable_cnt == DB_MAX) ? stable_cnt : stable_cnt + SC_W'(1);
    differs  = (res_key != held_q) || (res_key && (res_code != code_q));
    accept   = (cnt_next == DB_MAX) && differs;
  end

  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      col        <= 2'd0;
      settle_cnt <= '0;
      row_map    <= 16'd0;
      sw_s1      <= 1'b0;
      sw_s2      <= 1'b0;
      sw_d       <= 1'b0;
      row_s1     <= 4'b1111;
      row_s2     <= 4'b1111;
      cand_key   <= 1'b0;
      cand_code  <= 4'd0;
      stable_cnt <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sw_s1   <= kp.sw_clk;
      sw_s2   <= sw_s1;
      sw_d    <= sw_s2;
      row_s1  <= kp.key_row;
      row_s2  <= row_s1;
      valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (scan_tick) begin
            state      <= S_SETTLE;
            col        <= 2'd0;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_SAMPLE;
          else                  settle_cnt <= settle_cnt - CNT_W'(1);
        end
        S_SAMPLE: begin
          for (int r = 0; r < 4; r++) row_map[{2'(r), col}] <= ~row_s2[r];
          if (col == 2'd3) begin
            state <= S_EVAL;
          end else begin
            col        <= col + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
        end
        default: begin
          cand_key   <= res_key;
          cand_code  <= res_code;
          stable_cnt <= cnt_next;
          if (accept) begin
            if (res_key) begin
              code_q  <= res_code;
              valid_q <= 1'b1;
              held_q  <= 1'b1;
            end else begin
              held_q  <= 1'b0;
            end
          end
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a resistive-matrix keypad model.
module tb_keypad_scanner;
  localparam int P = 65;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pressed = 16'd0;
  logic [3:0]  noise = 4'd0;
  logic [3:0]  row_model;
  int          n_pass = 0;
  int          n_total = 0;
  int          v_cnt = 0;
  int          base;
  int          k;
  int          n;
  logic        found;

  keypad_scanner_if kif ();

  keypad_scanner #(.SETTLE_CYC(64), .DEBOUNCE_N(2)) dut (
    .clock_50m (clk),
    .rst       (rst),
    .kp        (kif.master)
  );

  always #10 clk = ~clk;

  // A pressed key shorts its row to its column; rows float high otherwise.
  always_comb begin
    row_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.key_col[c]) row_model[r] = 1'b0;
  end
  assign kif.key_row = row_model ^ noise;

  always @(posedge clk) if (kif.key_valid === 1'b1) v_cnt <= v_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic scan();
    @(negedge clk);
    kif.sw_clk = 1'b1;
    repeat (6) @(negedge clk);
    kif.sw_clk = 1'b0;
    repeat (4*P + 12) @(negedge clk);
  endtask

  initial begin
    kif.sw_clk = 1'b0;

    // 1: reset held with rows toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      noise = 4'($urandom);
      chk("reset_outputs", {kif.key_col, kif.key_code, kif.key_valid, kif.key_held}, {4'hf, 4'h0, 1'b0, 1'b0});
    end
    noise = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 2: row 2 / col 1 -> code 9
    pressed = 16'd1 << 9;
    scan();
    chk("t2_no_strobe_first_scan", 32'(v_cnt), 32'd0);
    base = v_cnt;
    @(negedge clk);
    kif.sw_clk = 1'b1;
    k = 0;
    found = 1'b0;
    while (!found && k < 400) begin
      @(posedge clk);
      k++;
      #1;
      if (kif.key_valid === 1'b1) found = 1'b1;
    end
    // Two synchroniser edges, then T+4P+2.
    chk("t2_valid_latency", 32'(k), 32'(4*P + 4));
    chk("t2_code", 32'(kif.key_code), 32'd9);
    chk("t2_held", 32'(kif.key_held), 32'd1);
    @(negedge clk);
    kif.sw_clk = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_one_strobe", 32'(v_cnt - base), 32'd1);
    for (int i = 0; i < 5; i++) scan();
    chk("t2_no_repeat", 32'(v_cnt - base), 32'd1);
    chk("t2_still_held", 32'(kif.key_held), 32'd1);

    // 3: release
    pressed = 16'd0;
    base = v_cnt;
    scan();
    chk("t3_held_after_one", 32'(kif.key_held), 32'd1);
    scan();
    chk("t3_held_after_two", 32'(kif.key_held), 32'd0);
    chk("t3_no_strobe", 32'(v_cnt - base), 32'd0);
    chk("t3_code_kept", 32'(kif.key_code), 32'd9);

    // 4: bouncing key 5, then steady
    base = v_cnt;
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? (16'd1 << 5) : 16'd0;
      scan();
    end
    chk("t4_bounce_no_strobe", 32'(v_cnt - base), 32'd0);
    chk("t4_bounce_not_held", 32'(kif.key_held), 32'd0);
    pressed = 16'd1 << 5;
    scan();
    scan();
    chk("t4_steady_strobe", 32'(v_cnt - base), 32'd1);
    chk("t4_code", 32'(kif.key_code), 32'd5);
    chk("t4_held", 32'(kif.key_held), 32'd1);

    // 5: keys 0 and 15 together are rejected
    pressed = 16'h8001;
    base = v_cnt;
    for (int i = 0; i < 4; i++) scan();
    chk("t5_ghost_no_strobe", 32'(v_cnt - base), 32'd0);
    chk("t5_ghost_not_held", 32'(kif.key_held), 32'd0);
    pressed = 16'h0001;
    scan();
    scan();
    chk("t5_key0_strobe", 32'(v_cnt - base), 32'd1);
    chk("t5_key0_code", 32'(kif.key_code), 32'd0);
    chk("t5_key0_held", 32'(kif.key_held), 32'd1);

    // 6a: reset during column 2 settle
    @(negedge clk);
    kif.sw_clk = 1'b1;
    k = 0;
    while (kif.key_col !== 4'b1011 && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 6) kif.sw_clk = 1'b0;
    end
    chk("t6_reached_col2", 32'(kif.key_col), 32'hb);
    kif.sw_clk = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_col_released", 32'(kif.key_col), 32'hf);
    chk("t6_held_cleared", 32'(kif.key_held), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (kif.key_col !== 4'b1111) n++;
    end
    chk("t6_no_scan_after_reset", 32'(n), 32'd0);

    // 6b: a second sw_clk pulse mid-scan neither restarts nor queues a scan
    pressed = 16'd1 << 7;
    @(negedge clk);
    kif.sw_clk = 1'b1;
    n = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (i == 6)   kif.sw_clk = 1'b0;
      if (i == 120) kif.sw_clk = 1'b1;
      if (i == 126) kif.sw_clk = 1'b0;
      if (kif.key_col !== 4'b1111) n++;
    end
    chk("t6_scan_length", 32'(n), 32'(4*P));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
